// File: rtl/rs_issue_select_if.sv
// Issue-slot bus between the RS select stage and the functional units.
// The select stage drives valid/packet per slot; the FU side answers with ready.
interface rs_issue_select_if #(
    parameter int ISSUE_WIDTH = 2,
    parameter int PKT_W       = 32
);
    logic [ISSUE_WIDTH-1:0]            slot_valid;
    logic [ISSUE_WIDTH-1:0]            slot_ready;
    logic [ISSUE_WIDTH-1:0][PKT_W-1:0] slot_pkt;

    modport master (
        output slot_valid,
        output slot_pkt,
        input  slot_ready
    );

    modport slave (
        input  slot_valid,
        input  slot_pkt,
        output slot_ready
    );
endinterface

// File: rtl/rs_issue_select.sv
// Round-robin issue selector: picks up to ISSUE_WIDTH ready RS entries per cycle,
// grants them back to the entries and latches their packets into per-slot FU registers.
module rs_issue_select #(
    parameter int RS_DEPTH    = 16,
    parameter int ISSUE_WIDTH = 2,
    parameter int FU_NUM      = 8,
    parameter int PKT_W       = 32,
    localparam int FT_W       = $clog2(FU_NUM),
    localparam int PTR_W      = $clog2(RS_DEPTH)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush_i,
    input  logic [RS_DEPTH-1:0]            entry_ready_i,
    input  logic [RS_DEPTH-1:0][FT_W-1:0]  entry_fu_type_i,
    input  logic [RS_DEPTH-1:0][PKT_W-1:0] entry_pkt_i,
    input  logic [FU_NUM-1:0]              fu_free_i,
    output logic [RS_DEPTH-1:0]            issue_grant_o,
    output logic [PTR_W-1:0]               rr_ptr_o,
    rs_issue_select_if.master              issue
);
    localparam int SW = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1;

    logic [ISSUE_WIDTH-1:0]            slot_valid_q;
    logic [ISSUE_WIDTH-1:0][PKT_W-1:0] slot_pkt_q;
    logic [PTR_W-1:0]                  rr_ptr;

    logic [ISSUE_WIDTH-1:0]            avail;
    logic [ISSUE_WIDTH-1:0]            load;
    logic [ISSUE_WIDTH-1:0][PTR_W-1:0] load_src;
    logic [ISSUE_WIDTH-1:0][PTR_W-1:0] pick;
    logic [RS_DEPTH-1:0]               grant;
    logic [FU_NUM-1:0]                 fu_used;
    logic [PTR_W-1:0]                  idx;
    logic [PTR_W-1:0]                  last_idx;
    logic                              any_grant;
    int                                n_avail;
    int                                n_pick;
    int                                n_map;

    // Scan from the round-robin pointer, handing the n-th candidate to the n-th free slot.
    always_comb begin
        avail     = '0;
        load      = '0;
        load_src  = '0;
        pick      = '0;
        grant     = '0;
        fu_used   = '0;
        idx       = '0;
        last_idx  = rr_ptr;
        any_grant = 1'b0;
        n_avail   = 0;
        n_pick    = 0;
        n_map     = 0;

        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            avail[SW'(k)] = !slot_valid_q[SW'(k)] || issue.slot_ready[SW'(k)];
            if (avail[SW'(k)]) begin
                n_avail = n_avail + 1;
            end
        end

        for (int i = 0; i < RS_DEPTH; i++) begin
            idx = PTR_W'((int'(rr_ptr) + i) % RS_DEPTH);
            if (n_pick < n_avail && entry_ready_i[idx] &&
                fu_free_i[entry_fu_type_i[idx]] && !fu_used[entry_fu_type_i[idx]]) begin
                grant[idx]                       = 1'b1;
                fu_used[entry_fu_type_i[idx]]    = 1'b1;
                pick[SW'(n_pick)]                = idx;
                last_idx                         = idx;
                any_grant                        = 1'b1;
                n_pick                           = n_pick + 1;
            end
        end

        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            if (avail[SW'(k)] && n_map < n_pick) begin
                load[SW'(k)]     = 1'b1;
                load_src[SW'(k)] = pick[SW'(n_map)];
                n_map            = n_map + 1;
            end
        end

        // A squash or a held reset must not free any entry.
        if (flush_i || !reset) begin
            grant     = '0;
            load      = '0;
            any_grant = 1'b0;
        end
    end

    // Slot registers: flush beats load, load beats drain, otherwise hold for the stalled FU.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_valid_q <= '0;
            slot_pkt_q   <= '0;
            rr_ptr       <= '0;
        end else begin
            for (int k = 0; k < ISSUE_WIDTH; k++) begin
                if (flush_i) begin
                    slot_valid_q[SW'(k)] <= 1'b0;
                end else if (load[SW'(k)]) begin
                    slot_valid_q[SW'(k)] <= 1'b1;
                    slot_pkt_q[SW'(k)]   <= entry_pkt_i[load_src[SW'(k)]];
                end else if (slot_valid_q[SW'(k)] && issue.slot_ready[SW'(k)]) begin
                    slot_valid_q[SW'(k)] <= 1'b0;
                end
            end
            if (any_grant) begin
                rr_ptr <= (last_idx == PTR_W'(RS_DEPTH - 1)) ? '0 : last_idx + 1'b1;
            end
        end
    end

    assign issue_grant_o    = grant;
    assign rr_ptr_o         = rr_ptr;
    assign issue.slot_valid = slot_valid_q;
    assign issue.slot_pkt   = slot_pkt_q;
endmodule

// File: tb/tb_rs_issue_select.sv
// Bench for rs_issue_select: a table of single-cycle vectors with hand-derived expectations,
// followed by multi-cycle stall and reset-mid-stall sequences.
module tb_rs_issue_select;
    localparam int RS_DEPTH    = 16;
    localparam int ISSUE_WIDTH = 2;
    localparam int FU_NUM      = 8;
    localparam int PKT_W       = 32;
    localparam int NV          = 13;

    typedef struct {
        logic [15:0]      ready;
        logic [15:0][2:0] types;
        logic [7:0]       fu_free;
        logic [1:0]       slot_ready;
        logic             flush;
        logic [15:0]      exp_grant;
        logic [1:0]       exp_valid;
        int               exp_src0;
        int               exp_src1;
        logic [3:0]       exp_rr;
    } vec_t;

    typedef struct {
        int          slot;
        logic [31:0] pkt;
    } sb_t;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             flush_i = 1'b0;
    logic [15:0]      entry_ready_i = '0;
    logic [15:0][2:0] entry_fu_type_i = '0;
    logic [15:0][31:0] entry_pkt_i = '0;
    logic [7:0]       fu_free_i = 8'hFF;
    logic [15:0]      issue_grant_o;
    logic [3:0]       rr_ptr_o;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[NV];
    sb_t  sb[$];
    logic [31:0] save0;
    logic [31:0] save1;

    rs_issue_select_if #(.ISSUE_WIDTH(ISSUE_WIDTH), .PKT_W(PKT_W)) issue ();

    rs_issue_select #(
        .RS_DEPTH(RS_DEPTH), .ISSUE_WIDTH(ISSUE_WIDTH), .FU_NUM(FU_NUM), .PKT_W(PKT_W)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .flush_i         (flush_i),
        .entry_ready_i   (entry_ready_i),
        .entry_fu_type_i (entry_fu_type_i),
        .entry_pkt_i     (entry_pkt_i),
        .fu_free_i       (fu_free_i),
        .issue_grant_o   (issue_grant_o),
        .rr_ptr_o        (rr_ptr_o),
        .issue           (issue)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] pkt_of(input int ep, input int e);
        return 32'hC0DE_0000 + 32'(ep) * 32'h100 + 32'(e);
    endfunction

    function automatic logic [15:0][2:0] def_types();
        logic [15:0][2:0] r;
        for (int e = 0; e < 16; e++) r[e] = 3'(e % 8);
        return r;
    endfunction

    function automatic vec_t mk(input logic [15:0] ready, input logic [7:0] fu_free,
                                input logic [1:0] slot_ready, input logic flush,
                                input logic [15:0] exp_grant, input logic [1:0] exp_valid,
                                input int src0, input int src1, input logic [3:0] exp_rr);
        vec_t t;
        t.ready = ready;   t.types = def_types();  t.fu_free = fu_free;
        t.slot_ready = slot_ready;  t.flush = flush;  t.exp_grant = exp_grant;
        t.exp_valid = exp_valid;  t.exp_src0 = src0;  t.exp_src1 = src1;  t.exp_rr = exp_rr;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_pkts(input int ep);
        for (int e = 0; e < 16; e++) entry_pkt_i[e] = pkt_of(ep, e);
    endtask

    // Drive one vector and queue the packets it should land in the slots.
    task automatic apply_stimulus(input vec_t t, input int ep);
        sb_t s;
        entry_ready_i   = t.ready;
        entry_fu_type_i = t.types;
        fu_free_i       = t.fu_free;
        issue.slot_ready = t.slot_ready;
        flush_i         = t.flush;
        drive_pkts(ep);
        if (t.exp_src0 >= 0) begin s.slot = 0; s.pkt = pkt_of(ep, t.exp_src0); sb.push_back(s); end
        if (t.exp_src1 >= 0) begin s.slot = 1; s.pkt = pkt_of(ep, t.exp_src1); sb.push_back(s); end
    endtask

    task automatic check_output(input vec_t t, input int v);
        sb_t s;
        check($sformatf("v%0d_valid", v), 32'(issue.slot_valid), 32'(t.exp_valid));
        check($sformatf("v%0d_rr", v), 32'(rr_ptr_o), 32'(t.exp_rr));
        while (sb.size() > 0) begin
            s = sb.pop_front();
            check($sformatf("v%0d_pkt%0d", v, s.slot), issue.slot_pkt[s.slot], s.pkt);
        end
    endtask

    task automatic drive_simple(input logic [15:0] ready, input logic [1:0] slot_ready, input int ep);
        entry_ready_i    = ready;
        entry_fu_type_i  = def_types();
        fu_free_i        = 8'hFF;
        issue.slot_ready = slot_ready;
        flush_i          = 1'b0;
        drive_pkts(ep);
    endtask

    initial begin
        tbl[0]  = mk(16'h0028, 8'hFF, 2'b11, 1'b0, 16'h0028, 2'b11,  3,  5, 4'd6);
        tbl[0].types[3] = 3'd0;
        tbl[0].types[5] = 3'd1;
        tbl[1]  = mk(16'h0000, 8'hFF, 2'b11, 1'b0, 16'h0000, 2'b00, -1, -1, 4'd6);
        tbl[2]  = mk(16'h2000, 8'hFF, 2'b11, 1'b0, 16'h2000, 2'b01, 13, -1, 4'd14);
        tbl[3]  = mk(16'h8002, 8'hFF, 2'b11, 1'b0, 16'h8002, 2'b11, 15,  1, 4'd2);
        tbl[4]  = mk(16'h0054, 8'hFF, 2'b11, 1'b0, 16'h0044, 2'b11,  2,  6, 4'd7);
        tbl[4].types[2] = 3'd3;
        tbl[4].types[4] = 3'd3;
        tbl[4].types[6] = 3'd0;
        tbl[5]  = mk(16'h0010, 8'hFF, 2'b11, 1'b0, 16'h0010, 2'b01,  4, -1, 4'd5);
        tbl[5].types[4] = 3'd3;
        tbl[6]  = mk(16'h1800, 8'hF7, 2'b11, 1'b0, 16'h1000, 2'b01, 12, -1, 4'd13);
        tbl[7]  = mk(16'h0007, 8'hFF, 2'b00, 1'b0, 16'h0001, 2'b11, -1,  0, 4'd1);
        tbl[8]  = mk(16'h0007, 8'hFF, 2'b00, 1'b0, 16'h0000, 2'b11, -1, -1, 4'd1);
        tbl[9]  = mk(16'h00F0, 8'hFF, 2'b01, 1'b0, 16'h0010, 2'b11,  4, -1, 4'd5);
        tbl[10] = mk(16'hFFFF, 8'hFF, 2'b00, 1'b1, 16'h0000, 2'b00, -1, -1, 4'd5);
        tbl[11] = mk(16'hFFFF, 8'hFF, 2'b11, 1'b0, 16'h0060, 2'b11,  5,  6, 4'd7);
        tbl[12] = mk(16'hFFFF, 8'h00, 2'b11, 1'b0, 16'h0000, 2'b00, -1, -1, 4'd7);

        // Reset held with ready entries: nothing may be granted or latched.
        drive_simple(16'h0028, 2'b11, 0);
        #3;
        check("rst_grant", 32'(issue_grant_o), 32'h0);
        check("rst_valid", 32'(issue.slot_valid), 32'h0);
        check("rst_rr", 32'(rr_ptr_o), 32'h0);
        @(posedge clock); #1;
        check("rst_edge_valid", 32'(issue.slot_valid), 32'h0);
        check("rst_edge_grant", 32'(issue_grant_o), 32'h0);
        @(negedge clock);
        reset = 1'b1;

        for (int v = 0; v < NV; v++) begin
            apply_stimulus(tbl[v], v + 1);
            #1;
            check($sformatf("v%0d_grant", v), 32'(issue_grant_o), 32'(tbl[v].exp_grant));
            @(posedge clock); #1;
            check_output(tbl[v], v);
            @(negedge clock);
        end

        // Stall: slot0 loaded, then held through four stalled cycles while packets change.
        flush_i = 1'b0;
        drive_simple(16'h0001, 2'b11, 100);
        #1 check("st_grant0", 32'(issue_grant_o), 32'h0001);
        @(posedge clock); #1;
        save0 = pkt_of(100, 0);
        check("st_valid0", 32'(issue.slot_valid), 32'h1);
        check("st_pkt0", issue.slot_pkt[0], save0);
        check("st_rr0", 32'(rr_ptr_o), 32'd1);
        @(negedge clock);
        drive_simple(16'h0700, 2'b00, 101);
        #1 check("st_grant1", 32'(issue_grant_o), 32'h0100);
        @(posedge clock); #1;
        save1 = pkt_of(101, 8);
        check("st_valid1", 32'(issue.slot_valid), 32'h3);
        check("st_pkt1", issue.slot_pkt[1], save1);
        check("st_hold0_0", issue.slot_pkt[0], save0);
        check("st_rr1", 32'(rr_ptr_o), 32'd9);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            drive_simple(16'h0700, 2'b00, 102 + c);
            #1 check($sformatf("st_grant_c%0d", c), 32'(issue_grant_o), 32'h0);
            @(posedge clock); #1;
            check($sformatf("st_valid_c%0d", c), 32'(issue.slot_valid), 32'h3);
            check($sformatf("st_hold0_c%0d", c), issue.slot_pkt[0], save0);
            check($sformatf("st_hold1_c%0d", c), issue.slot_pkt[1], save1);
            check($sformatf("st_rr_c%0d", c), 32'(rr_ptr_o), 32'd9);
        end

        // Reset asserted mid-stall, away from any clock edge, clears state at once.
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(issue.slot_valid), 32'h0);
        check("mid_rst_rr", 32'(rr_ptr_o), 32'h0);
        check("mid_rst_grant", 32'(issue_grant_o), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        drive_simple(16'h0028, 2'b11, 200);
        #1 check("post_rst_grant", 32'(issue_grant_o), 32'h0028);
        @(posedge clock); #1;
        check("post_rst_valid", 32'(issue.slot_valid), 32'h3);
        check("post_rst_pkt0", issue.slot_pkt[0], pkt_of(200, 3));
        check("post_rst_pkt1", issue.slot_pkt[1], pkt_of(200, 5));
        check("post_rst_rr", 32'(rr_ptr_o), 32'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
